divider_sequencer: RTL
======================

Name: divider_sequencer

Overview:
- Multi-cycle sequencer for the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the EX-stage ALU and is selected by decode when funct7 is 0000001 and funct3[2] is 1.
- Runs a radix-2 restoring divide over XLEN iterations, with a start/busy/result_valid handshake.
- Drives a stall request that freezes IF/ID/EX until the result is ready.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  EX holds a divide-group instruction; sampled in IDLE or DONE
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is ignored (no accept)
operand_a  input  XLEN  dividend (rs1)
operand_b  input  XLEN  divisor (rs2)
flush  input  1  branch/jump flush from EX; kills the in-flight operation
busy  output  1  high in PREP, ITER, FIX
stall  output  1  pipeline freeze request
result_valid  output  1  one-cycle pulse, result is valid
result  output  XLEN  quotient or remainder

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - busy, stall, result_valid = 0; result = 0.
  - All internal registers = 0.
  - Reset mid-operation discards the operation with no result pulse.
- States:
  - IDLE -> PREP on start & funct3[2] & no special case.
  - IDLE -> DONE on start & special case.
  - PREP -> ITER.
  - ITER -> ITER while count != XLEN-1, else FIX.
  - FIX -> DONE.
  - DONE -> same transitions as IDLE (back-to-back accept allowed), else IDLE.
- Accept: operand_a, operand_b and funct3 are latched on the accept edge. Later input changes are ignored.
- PREP: take absolute values for signed ops, record the quotient sign (sign_a ^ sign_b) and remainder sign (sign_a), clear the partial remainder, set count = 0.
- ITER: one restoring step per cycle (shift remainder/quotient left, trial subtract, keep the result if non-negative, set the quotient bit). count increments and wraps only via the state change.
- FIX: negate the quotient/remainder per the recorded signs (signed ops only), then select quotient (funct3[1]=0) or remainder (funct3[1]=1) into the result register.
- Latency: accept edge at cycle 0, PREP at cycle 1, ITER at cycles 2..33, FIX at cycle 34, result_valid high during cycle 35. Total XLEN+4 cycles.
- Special cases resolve with 1-cycle latency (DONE in the cycle after accept):
  - Divisor 0: DIV/DIVU result = all ones; REM/REMU result = operand_a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): DIV result = 0x80000000; REM result = 0.
- result holds its value after DONE until the next FIX/DONE load.
- result_valid is high only in DONE.
- stall = busy | (accept condition in IDLE/DONE), combinational. It is high in the accept cycle and low in DONE, so the instruction retires in DONE.
- start while busy is ignored.
- flush:
  - Synchronous, has priority over start and over every state transition.
  - Next state is IDLE; result_valid does not pulse; a start in the same cycle is not accepted.
  - stall drops the cycle after flush.
- funct3[2]=0 with start: no accept, stall stays 0.

Decomposition:
- Shared package rv32m_pkg holds:
  - funct3 constants (F3_DIV, F3_DIVU, F3_REM, F3_REMU).
  - State enum (IDLE, PREP, ITER, FIX, DONE).
  - XLEN.
- One natural sub-module, div_step: a combinational single restoring iteration. Inputs: partial remainder, quotient, divisor. Outputs: next remainder and next quotient.

Test Plan:
- DIVU a=100, b=7 -> stall high in the accept cycle through cycle 34; result_valid at cycle 35 with result=14. REMU, same operands -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD. REM, same operands -> result=0xFFFFFFFF.
- DIVU a=5, b=0 -> result_valid at cycle 1 with result=0xFFFFFFFF. REM a=5, b=0 -> result=5.
- DIV a=0x80000000, b=0xFFFFFFFF -> cycle-1 result 0x80000000. REM, same operands -> result=0.
- Flush asserted at cycle 10 of a DIVU:
  - Required: IDLE next cycle, no result_valid, stall low.
  - A following DIVU 9/3 returns 3 with full latency.
- reset_n pulsed low mid-ITER -> busy/stall/result_valid/result all 0 immediately.
- Back-to-back: start held in DONE of 100/7 -> second op accepted, its result is valid XLEN+4 cycles later.

Source files
------------

// File: rtl/rv32m_pkg.sv
// ---------------------------------------------------------------------------
// rv32m_pkg
// Shared definitions for the RV32M divide group sequencer:
//   XLEN            - operand/result width (also the iteration count)
//   F3_DIV..F3_REMU - funct3 encodings of the divide group
//   state_t         - sequencer state encoding
// ---------------------------------------------------------------------------
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/divider_sequencer_if.sv
// ---------------------------------------------------------------------------
// divider_sequencer_if
// Handshake/data bundle between the EX stage and the divide sequencer.
//   start, funct3, operand_a, operand_b, flush : EX -> divider
//   busy, stall, result_valid, result           : divider -> EX
// master modport : EX stage side
// slave modport  : divider side
// ---------------------------------------------------------------------------
interface divider_sequencer_if #(
  parameter int XLEN = rv32m_pkg::XLEN
);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, operand_a, operand_b, flush,
    input  busy, stall, result_valid, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, flush,
    output busy, stall, result_valid, result
  );

endinterface

// File: rtl/divider_sequencer_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring divide iteration on unsigned magnitudes.
//   rem      : partial remainder (always < divisor on entry)
//   quo      : dividend bits still to be consumed, quotient bits shifted in
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this step
//   quo_next : quotient/dividend register after this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  always_comb begin
    // One extra bit holds the shifted remainder; since rem < divisor the
    // shifted value is < 2*divisor, so the top bit of trial is a clean borrow.
    rem_sh = {rem, quo[XLEN-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_sequencer.sv
// ---------------------------------------------------------------------------
// divider_sequencer
// Multi-cycle DIV/DIVU/REM/REMU unit beside the EX-stage ALU. Radix-2
// restoring divide over XLEN iterations; divide-by-zero and signed overflow
// resolve in one cycle. Drives a pipeline stall until the result is ready.
//   clk     : pipeline clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of divider_sequencer_if
//             (start/funct3/operands/flush in; busy/stall/result_valid/result out)
// Timing: accept in cycle 0, PREP 1, ITER 2..XLEN+1, FIX XLEN+2, DONE XLEN+3.
// ---------------------------------------------------------------------------
module divider_sequencer
  import rv32m_pkg::*;
#(
  parameter int XLEN = rv32m_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  divider_sequencer_if.slave   bus
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [1:0]      op_f3;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic            q_neg;
  logic            r_neg;
  logic            busy_q;
  logic            rv_q;
  logic [XLEN-1:0] result_q;

  logic            req;
  logic            req_signed;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            op_signed;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;

  // Two's-complement negate when en is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // Magnitude of a value interpreted as signed when is_sgn is set.
  // INT_MIN maps to itself, which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic            is_sgn);
    logic signed [XLEN-1:0] s;
    s = v;
    return cond_neg(v, is_sgn && (s < 0));
  endfunction

  always_comb begin
    req        = bus.start & bus.funct3[2] & ~bus.flush &
                 ((state == IDLE) | (state == DONE));
    req_signed = ~bus.funct3[0];
    special    = 1'b0;
    special_res = '0;
    if (bus.operand_b == '0) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.operand_a : '1;
    end else if (req_signed && bus.operand_a == INT_MIN && bus.operand_b == '1) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? '0 : INT_MIN;
    end
  end

  assign op_signed = ~op_f3[0];

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_f3    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      // Kill whatever is in flight; result keeps its last value.
      state  <= IDLE;
      busy_q <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          rv_q  <= 1'b0;
          state <= IDLE;
          if (req) begin
            op_a  <= bus.operand_a;
            op_b  <= bus.operand_b;
            op_f3 <= bus.funct3[1:0];
            if (special) begin
              result_q <= special_res;
              rv_q     <= 1'b1;
              state    <= DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= PREP;
            end
          end
        end
        PREP: begin
          rem_q  <= '0;
          quo_q  <= mag(op_a, op_signed);
          dvsr_q <= mag(op_b, op_signed);
          q_neg  <= op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
          r_neg  <= op_signed & op_a[XLEN-1];
          count  <= '0;
          state  <= ITER;
        end
        ITER: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (count == CNT_W'(XLEN-1)) state <= FIX;
          else                         count <= count + 1'b1;
        end
        FIX: begin
          result_q <= op_f3[1] ? cond_neg(rem_q, r_neg) : cond_neg(quo_q, q_neg);
          busy_q   <= 1'b0;
          rv_q     <= 1'b1;
          state    <= DONE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.stall        = busy_q | req;
  assign bus.result_valid = rv_q;
  assign bus.result       = result_q;

endmodule
